// File: rtl/instr_decode_stage.sv
// RV32I decode stage: field extraction, immediate generation and control flags for the register file and execute stage.
// Latency: 1 cycle from accept to registered outputs.
// Backpressure: a main+skid pair absorbs one extra instruction so that if_ready can be a plain flop.
module instr_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            flush,
   input  logic            if_valid,
   output logic            if_ready,
   input  logic [31:0]     if_instr,
   input  logic [XLEN-1:0] if_pc,
   output logic            id_valid,
   input  logic            id_ready,
   output logic [XLEN-1:0] id_pc,
   output logic [4:0]      rs1,
   output logic [4:0]      rs2,
   output logic [4:0]      rd,
   output logic [6:0]      opcode,
   output logic [2:0]      funct3,
   output logic [6:0]      funct7,
   output logic [XLEN-1:0] imm,
   output logic            reg_write,
   output logic            alu_src_imm,
   output logic            mem_read,
   output logic            mem_write,
   output logic            branch,
   output logic            jump,
   output logic            illegal
);

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [6:0]      opcode;
      logic [2:0]      funct3;
      logic [6:0]      funct7;
      logic [XLEN-1:0] imm;
      logic            reg_write;
      logic            alu_src_imm;
      logic            mem_read;
      logic            mem_write;
      logic            branch;
      logic            jump;
      logic            illegal;
   } dec_t;

   logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
   dec_t        dec;
   dec_t        main_q, skid_q;
   logic        main_vld, skid_vld;
   logic        accept, drain;

   assign imm_i = {{20{if_instr[31]}}, if_instr[31:20]};
   assign imm_s = {{20{if_instr[31]}}, if_instr[31:25], if_instr[11:7]};
   assign imm_b = {{19{if_instr[31]}}, if_instr[31], if_instr[7], if_instr[30:25], if_instr[11:8], 1'b0};
   assign imm_u = {if_instr[31:12], 12'b0};
   assign imm_j = {{11{if_instr[31]}}, if_instr[31], if_instr[19:12], if_instr[20], if_instr[30:21], 1'b0};

   always_comb begin
      dec        = '0;
      dec.pc     = if_pc;
      dec.rs1    = if_instr[19:15];
      dec.rs2    = if_instr[24:20];
      dec.rd     = if_instr[11:7];
      dec.opcode = if_instr[6:0];
      dec.funct3 = if_instr[14:12];
      dec.funct7 = if_instr[31:25];
      case (if_instr[6:0])
         OPC_LUI, OPC_AUIPC: begin
            dec.imm = imm_u; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_JAL: begin
            dec.imm = imm_j; dec.reg_write = 1'b1; dec.jump = 1'b1;
         end
         OPC_JALR: begin
            dec.imm = imm_i; dec.reg_write = 1'b1; dec.jump = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_BRANCH: begin
            dec.imm = imm_b; dec.branch = 1'b1;
         end
         OPC_LOAD: begin
            dec.imm = imm_i; dec.reg_write = 1'b1; dec.mem_read = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_STORE: begin
            dec.imm = imm_s; dec.mem_write = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_OPIMM: begin
            dec.imm = imm_i; dec.reg_write = 1'b1; dec.alu_src_imm = 1'b1;
         end
         OPC_OP: begin
            dec.reg_write = 1'b1;
         end
         default: dec.illegal = 1'b1;
      endcase
      // The register file writes x0 blindly, so suppress it here.
      if (dec.rd == 5'd0) dec.reg_write = 1'b0;
   end

   assign accept = if_valid & if_ready;
   assign drain  = main_vld & id_ready;

   always_ff @(posedge clk) begin
      if (reset) begin
         main_q   <= '0;
         skid_q   <= '0;
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         if_ready <= 1'b1;
      end else if (flush) begin
         main_vld <= 1'b0;
         skid_vld <= 1'b0;
         if_ready <= 1'b1;
      end else if (skid_vld) begin
         // if_ready is low while skid is occupied, so nothing new arrives here.
         if (drain) begin
            main_q   <= skid_q;
            skid_vld <= 1'b0;
            if_ready <= 1'b1;
         end
      end else if (accept) begin
         if (!main_vld || drain) begin
            main_q   <= dec;
            main_vld <= 1'b1;
         end else begin
            skid_q   <= dec;
            skid_vld <= 1'b1;
            if_ready <= 1'b0;
         end
      end else if (drain) begin
         main_vld <= 1'b0;
      end
   end

   assign id_valid    = main_vld;
   assign id_pc       = main_q.pc;
   assign rs1         = main_q.rs1;
   assign rs2         = main_q.rs2;
   assign rd          = main_q.rd;
   assign opcode      = main_q.opcode;
   assign funct3      = main_q.funct3;
   assign funct7      = main_q.funct7;
   assign imm         = main_q.imm;
   assign reg_write   = main_q.reg_write;
   assign alu_src_imm = main_q.alu_src_imm;
   assign mem_read    = main_q.mem_read;
   assign mem_write   = main_q.mem_write;
   assign branch      = main_q.branch;
   assign jump        = main_q.jump;
   assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_instr_decode_stage.sv
// Directed bench for instr_decode_stage: decode vectors, skid backpressure, flush and reset.
module tb_instr_decode_stage;

   logic        clk = 1'b0;
   logic        reset, flush, if_valid, if_ready, id_valid, id_ready;
   logic [31:0] if_instr, if_pc, id_pc, imm;
   logic [4:0]  rs1, rs2, rd;
   logic [6:0]  opcode, funct7;
   logic [2:0]  funct3;
   logic        reg_write, alu_src_imm, mem_read, mem_write, branch, jump, illegal;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   instr_decode_stage #(.XLEN(32)) dut (
      .clk(clk), .reset(reset), .flush(flush),
      .if_valid(if_valid), .if_ready(if_ready), .if_instr(if_instr), .if_pc(if_pc),
      .id_valid(id_valid), .id_ready(id_ready), .id_pc(id_pc),
      .rs1(rs1), .rs2(rs2), .rd(rd), .opcode(opcode), .funct3(funct3), .funct7(funct7),
      .imm(imm), .reg_write(reg_write), .alu_src_imm(alu_src_imm),
      .mem_read(mem_read), .mem_write(mem_write), .branch(branch), .jump(jump),
      .illegal(illegal)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Advance one edge; outputs are sampled 1ns later and inputs are updated there too.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic present(input logic [31:0] instr, input logic [31:0] pc);
      if_valid = 1'b1;
      if_instr = instr;
      if_pc    = pc;
   endtask

   initial begin
      reset = 1'b1; flush = 1'b0; if_valid = 1'b0; if_instr = '0; if_pc = '0; id_ready = 1'b1;
      tick(); tick();
      chk("rst_id_valid", id_valid, 0);
      chk("rst_if_ready", if_ready, 1);
      chk("rst_imm", imm, 0);
      chk("rst_rd", rd, 0);
      chk("rst_reg_write", reg_write, 0);
      chk("rst_id_pc", id_pc, 0);
      reset = 1'b0;

      // Streaming decode at full rate
      present(32'hFFF08293, 32'h100); tick();
      chk("addi_vld", id_valid, 1);
      chk("addi_pc", id_pc, 32'h100);
      chk("addi_rs1", rs1, 1);
      chk("addi_rd", rd, 5);
      chk("addi_opcode", opcode, 7'h13);
      chk("addi_imm", imm, 32'hFFFFFFFF);
      chk("addi_regw", reg_write, 1);
      chk("addi_alusrc", alu_src_imm, 1);

      present(32'h0021A423, 32'h104); tick();
      chk("sw_vld", id_valid, 1);
      chk("sw_pc", id_pc, 32'h104);
      chk("sw_rs1", rs1, 3);
      chk("sw_rs2", rs2, 2);
      chk("sw_funct3", funct3, 3'b010);
      chk("sw_imm", imm, 8);
      chk("sw_memw", mem_write, 1);
      chk("sw_regw", reg_write, 0);

      present(32'h123453B7, 32'h108); tick();
      chk("lui_imm", imm, 32'h12345000);
      chk("lui_rd", rd, 7);
      chk("lui_regw", reg_write, 1);

      present(32'h00000013, 32'h10C); tick();
      chk("nop_regw", reg_write, 0);
      chk("nop_illegal", illegal, 0);

      present(32'hFE208EE3, 32'h110); tick();
      chk("beq_imm", imm, 32'hFFFFFFFC);
      chk("beq_branch", branch, 1);
      chk("beq_regw", reg_write, 0);

      present(32'h008000EF, 32'h114); tick();
      chk("jal_imm", imm, 8);
      chk("jal_jump", jump, 1);
      chk("jal_regw", reg_write, 1);

      present(32'h00000000, 32'h118); tick();
      chk("zero_illegal", illegal, 1);
      chk("zero_imm", imm, 0);
      chk("zero_flags", {reg_write, alu_src_imm, mem_read, mem_write, branch, jump}, 0);

      if_valid = 1'b0; tick();
      chk("idle_vld", id_valid, 0);

      // Backpressure: three offered, two taken, then all drain in order
      id_ready = 1'b0;
      present(32'hFFF08293, 32'h200); tick();
      chk("bp_a_vld", id_valid, 1);
      chk("bp_a_rdy", if_ready, 1);
      present(32'h0021A423, 32'h204); tick();
      chk("bp_b_rdy", if_ready, 0);
      chk("bp_b_hold_pc", id_pc, 32'h200);
      present(32'h123453B7, 32'h208); tick();
      chk("bp_c_hold_pc", id_pc, 32'h200);
      chk("bp_c_hold_rd", rd, 5);
      chk("bp_c_rdy", if_ready, 0);
      id_ready = 1'b1; tick();
      chk("bp_drain1_pc", id_pc, 32'h204);
      chk("bp_drain1_memw", mem_write, 1);
      chk("bp_drain1_rdy", if_ready, 1);
      tick();
      chk("bp_drain2_pc", id_pc, 32'h208);
      chk("bp_drain2_rd", rd, 7);
      chk("bp_drain2_vld", id_valid, 1);
      if_valid = 1'b0; tick();
      chk("bp_empty_vld", id_valid, 0);

      // Flush with skid full and a new instruction offered
      id_ready = 1'b0;
      present(32'hFFF08293, 32'h300); tick();
      present(32'h0021A423, 32'h304); tick();
      chk("fl_skid_rdy", if_ready, 0);
      flush = 1'b1; present(32'h123453B7, 32'h308); tick();
      chk("fl_vld", id_valid, 0);
      chk("fl_rdy", if_ready, 1);
      flush = 1'b0; if_valid = 1'b0; id_ready = 1'b1; tick();
      chk("fl_after1_vld", id_valid, 0);
      tick();
      chk("fl_after2_vld", id_valid, 0);

      // Flush while an accept happens: the incoming instruction is dropped
      flush = 1'b1; present(32'h00000013, 32'h400); tick();
      chk("fl_acc_vld", id_valid, 0);
      flush = 1'b0; if_valid = 1'b0; tick();
      chk("fl_acc_after_vld", id_valid, 0);

      // Reset mid-operation zeroes the data outputs
      present(32'h123453B7, 32'h500); tick();
      chk("pre_rst_vld", id_valid, 1);
      if_valid = 1'b0; reset = 1'b1; tick();
      chk("mid_rst_vld", id_valid, 0);
      chk("mid_rst_imm", imm, 0);
      chk("mid_rst_pc", id_pc, 0);
      chk("mid_rst_rdy", if_ready, 1);
      reset = 1'b0; tick();

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/instr_decode_stage.md
# instr_decode_stage

Pipelined RV32I instruction decode stage sitting directly upstream of the register file. Accepts fetched instructions over a valid/ready handshake, extracts register indices, generates the sign-extended immediate and control flags, and presents them registered to the register-file read ports and the execute stage. A two-entry skid buffer (main plus skid) sustains one instruction per cycle under downstream backpressure with a fully registered `if_ready`.

## Interface
- `XLEN`, 32, data and PC width; only 32 is supported.
- `clk`  in  1  clock; all state updates on posedge.
- `reset`  in  1  synchronous, active-high reset.
- `flush`  in  1  discard every held and incoming instruction (taken branch or jump).
- `if_valid`  in  1  fetch presents an instruction.
- `if_ready`  out  1  stage can accept; registered.
- `if_instr`  in  32  instruction word.
- `if_pc`  in  32  PC of `if_instr`.
- `id_valid`  out  1  decoded bundle valid.
- `id_ready`  in  1  execute accepts the bundle.
- `id_pc`  out  32  PC of the decoded instruction.
- `rs1`, `rs2`, `rd`  out  5 each  raw fields `[19:15]`, `[24:20]`, `[11:7]`; these feed the register file.
- `opcode`  out  7, `funct3`  out  3, `funct7`  out  7  raw fields.
- `imm`  out  32  sign-extended immediate.
- `reg_write`  out  1  instruction writes `rd`.
- `alu_src_imm`, `mem_read`, `mem_write`, `branch`, `jump`  out  1 each  control flags.
- `illegal`  out  1  opcode not in the RV32I base set.

## Operation
- Decode is combinational on `if_instr`. The result is captured into the main entry, or into the skid entry when main is held.
- Opcode classes and flags:
  - LUI `0110111`, AUIPC `0010111`: U-type, `reg_write`, `alu_src_imm`.
  - JAL `1101111`: J-type, `reg_write`, `jump`.
  - JALR `1100111`: I-type, `reg_write`, `jump`, `alu_src_imm`.
  - BRANCH `1100011`: B-type, `branch`.
  - LOAD `0000011`: I-type, `reg_write`, `mem_read`, `alu_src_imm`.
  - STORE `0100011`: S-type, `mem_write`, `alu_src_imm`.
  - OP-IMM `0010011`: I-type, `reg_write`, `alu_src_imm`.
  - OP `0110011`: R-type, `reg_write`, `imm`=0.
  - Any other opcode: `illegal`=1, all control flags 0, `imm`=0.
- Immediate formats:
  - I: sext(`[31:20]`).
  - S: sext(`{[31:25],[11:7]}`).
  - B: sext(`{[31],[7],[30:25],[11:8],1'b0}`).
  - U: `{[31:12],12'b0}`.
  - J: sext(`{[31],[19:12],[20],[30:21],1'b0}`).
- `reg_write` is forced to 0 when `rd`==0. The register file does not protect x0, so this stage does.
- Raw fields are output for every class, including classes that do not use them.

## Timing
- Reset values: `id_valid`=0, `if_ready`=1, all other outputs 0, both entries empty.
- Latency: an instruction accepted at edge N appears on the outputs after edge N, provided main was empty or draining.
- Accept = `if_valid & if_ready`; drain = `id_valid & id_ready`. Outputs are held stable while `id_valid & !id_ready`.
- Main empty or draining, skid empty: an accepted instruction loads main.
- Main full and not draining, instruction accepted: it loads skid, and `if_ready` is 0 from the next cycle.
- Main draining while skid is full: skid moves to main and skid clears. `if_ready` is 1 from the next cycle; no accept occurs that cycle because `if_ready` was 0.
- Back-to-back accept and drain with skid empty sustain 1 instruction per cycle with no bubble.
- `flush` has priority over everything:
  - both entries clear, `id_valid`=0 and `if_ready`=1 next cycle;
  - an instruction presented with accept in the flush cycle is discarded.
- `reset` mid-operation behaves like `flush` and also zeroes all data outputs.

## Test plan
- `0xFFF08293` (addi x5,x1,-1), `id_ready`=1 -> next cycle `id_valid`=1, `rs1`=1, `rd`=5, `imm`=`0xFFFFFFFF`, `reg_write`=1, `alu_src_imm`=1.
- `0x0021A423` (sw x2,8(x3)) -> `rs1`=3, `rs2`=2, `imm`=8, `mem_write`=1, `reg_write`=0.
- `0x123453B7` (lui x7) -> `imm`=`0x12345000`, `rd`=7, `reg_write`=1. `0x00000013` (nop) -> `reg_write`=0.
- `0x00000000` -> `illegal`=1, all control flags 0.
- Backpressure: hold `id_ready`=0 and stream 3 instructions -> 2 accepted, `if_ready`=0 from the cycle after the 2nd. Release -> all 3 emerge in order with no loss or duplication.
- Skid full, then `flush` together with `if_valid` -> next cycle `id_valid`=0, `if_ready`=1, and the flushed instructions never appear.
